id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage MIPS datapath. It sits directly upstream of the ALU and feeds it.
- Captures decoded operands and control from ID.
- Translates ALUOp and funct into the 4-bit ALU operation code.
- Applies EX-stage forwarding muxes to produce the ALU's data_a and data_b.
- Passes MEM/WB control downstream.

Parameters:
WIDTH, 32, datapath width
RADDR, 5, register address width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
stall  in  1  hold all stage registers
flush  in  1  replace the stage contents with a bubble
in_valid  in  1  ID presents a real instruction
alu_op  in  2  main-control ALUOp
funct  in  6  instruction funct field
rs_data  in  WIDTH  register file read port A
rt_data  in  WIDTH  register file read port B
imm  in  WIDTH  sign-extended immediate
alu_src  in  1  1 = data_b takes imm
reg_dst  in  1  1 = write address is rd, 0 = rt
rt_addr  in  RADDR  rt field
rd_addr  in  RADDR  rd field
reg_write, mem_read, mem_write, mem_to_reg  in  1 each  control from ID
fwd_a, fwd_b  in  2 each  forwarding selects from the hazard unit
exmem_fwd  in  WIDTH  forward value from EX/MEM
memwb_fwd  in  WIDTH  forward value from MEM/WB
ex_valid  out  1  EX holds a real instruction
operation  out  4  ALU operation code
data_a, data_b  out  WIDTH  ALU operands
ex_store_data  out  WIDTH  forwarded rt, used as SW data
ex_wr_addr  out  RADDR  destination register
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control
ex_illegal  out  1  unsupported ALUOp/funct combination in EX

Behaviour:
- Reset (rst_n=0, async):
  - All registered fields cleared to 0, except operation = 4'b0010.
  - ex_valid = 0, ex_illegal = 0.
  - Outputs valid immediately, with no clock edge needed.
- Latency: 1 cycle, ID inputs to EX outputs.
- Per-edge priority: flush > stall > capture.
  - flush: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg and ex_illegal cleared. Datapath fields hold their values.
  - stall (no flush): every register holds.
  - Capture with in_valid=0: loads a bubble, with control and valid zeroed as for flush.
  - Capture with in_valid=1: loads all fields. ex_wr_addr = reg_dst ? rd_addr : rt_addr.
- ALU control, decoded at capture and registered:
  - ALUOp 00 -> 0010 (add, lw/sw)
  - ALUOp 01 -> 0110 (sub, beq)
  - ALUOp 10 with funct 100000 -> 0010 (add)
  - ALUOp 10 with funct 100010 -> 0110 (sub)
  - ALUOp 10 with funct 100100 -> 0000 (and)
  - ALUOp 10 with funct 100101 -> 0001 (or)
  - ALUOp 10 with funct 101010 -> 0111 (slt)
  - ALUOp 10 with funct 100111 -> 1100 (nor)
  - ALUOp 10 with any other funct, or ALUOp 11: operation = 0010, ex_illegal = 1, and ex_reg_write, ex_mem_write, ex_mem_read forced to 0.
- Forwarding is combinational on the registered rs/rt values. It is not registered, because hazard decisions are made in the same cycle.
  - fwd select codes: 00 = register value, 10 = exmem_fwd, 01 = memwb_fwd, 11 = exmem_fwd (EX/MEM wins).
  - data_a = fwd_a mux of registered rs.
  - ex_store_data = fwd_b mux of registered rt.
  - data_b = registered alu_src ? registered imm : ex_store_data.
- A stall held over many cycles keeps operation and control stable. data_a and data_b may still change with the forward inputs.
- No combinational path exists from ID inputs to any output.

Decomposition:
- Shared package alu_pkg holds:
  - ALUOp codes
  - R-type funct codes
  - 4-bit ALU operation codes (AND, OR, ADD, SUB, SLT, NOR)
  - forward-select encodings
- The ALU also uses this package.
- One combinational sub-module, alu_control: inputs alu_op and funct; outputs operation and illegal. It is reused by any later multicycle controller.

Test Plan:
- Reset check: assert rst_n low mid-cycle with the stage full -> all outputs 0 at once, operation=0010, ex_valid=0; release, then capture next edge.
- R-type capture: alu_op=10, funct=101010, rs=5, rt=7, reg_dst=1, rd=9, in_valid=1 -> next cycle operation=0111, data_a=5, data_b=7, ex_wr_addr=9, ex_valid=1. Repeat for every legal funct against its code.
- Immediate and store path: alu_op=00, alu_src=1, imm=0xFFFFFFFC, rt=0x1234, mem_write=1 -> operation=0010, data_b=0xFFFFFFFC, ex_store_data=0x1234, ex_mem_write=1.
- Forwarding: captured rs=1, rt=2 with exmem_fwd=0xAA, memwb_fwd=0xBB.
  - fwd_a 00/10/01/11 -> data_a = 1 / 0xAA / 0xBB / 0xAA.
  - Same sequence on fwd_b with alu_src=0 drives data_b and ex_store_data.
- Stall vs flush: load an instruction, assert stall for 3 cycles while changing inputs -> outputs unchanged. Then assert stall and flush together -> ex_valid=0 and all control 0 next edge.
- Illegal: alu_op=10, funct=000000, reg_write=1 -> ex_illegal=1, operation=0010, ex_reg_write=0. Next valid instruction clears ex_illegal.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the ID/EX stage, the ALU and any later
// controller. It holds the main-control ALUOp codes, the R-type funct codes,
// the 4-bit ALU operation codes and the forwarding-select encodings.
package alu_pkg;

    // Main-control ALUOp codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // lw/sw address add
    localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq compare
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode funct

    // R-type funct field codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Forwarding selects; 11 aliases EX/MEM because the younger result wins
    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_MEMWB  = 2'b01;
    localparam logic [1:0] FWD_EXMEM  = 2'b10;
    localparam logic [1:0] FWD_EXMEM2 = 2'b11;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of the ID-side inputs, hazard-unit controls and EX-side outputs of
// the ID/EX pipeline register. The master modport is the surrounding
// datapath, and the slave modport is the stage itself.
interface id_ex_stage_if #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
);
    logic             stall;
    logic             flush;
    logic             in_valid;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm;
    logic             alu_src;
    logic             reg_dst;
    logic [RADDR-1:0] rt_addr;
    logic [RADDR-1:0] rd_addr;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [WIDTH-1:0] exmem_fwd;
    logic [WIDTH-1:0] memwb_fwd;

    logic             ex_valid;
    logic [3:0]       operation;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [WIDTH-1:0] ex_store_data;
    logic [RADDR-1:0] ex_wr_addr;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_mem_to_reg;
    logic             ex_illegal;

    modport master (
        output stall, flush, in_valid, alu_op, funct, rs_data, rt_data, imm,
               alu_src, reg_dst, rt_addr, rd_addr, reg_write, mem_read,
               mem_write, mem_to_reg, fwd_a, fwd_b, exmem_fwd, memwb_fwd,
        input  ex_valid, operation, data_a, data_b, ex_store_data, ex_wr_addr,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal
    );

    modport slave (
        input  stall, flush, in_valid, alu_op, funct, rs_data, rt_data, imm,
               alu_src, reg_dst, rt_addr, rd_addr, reg_write, mem_read,
               mem_write, mem_to_reg, fwd_a, fwd_b, exmem_fwd, memwb_fwd,
        output ex_valid, operation, data_a, data_b, ex_store_data, ex_wr_addr,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal
    );
endinterface

// File: rtl/alu_control.sv
// Combinational ALU control. It maps ALUOp/funct to the 4-bit ALU operation
// and flags combinations it does not support. It is kept stand-alone so that
// a multicycle controller can reuse it.
module alu_control
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] operation,
    output logic       illegal
);

    // Decode; unsupported codes fall back to add and raise illegal
    always_comb begin
        operation = ALU_ADD;
        illegal   = 1'b0;
        case (alu_op)
            ALUOP_ADD: operation = ALU_ADD;
            ALUOP_SUB: operation = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: operation = ALU_ADD;
                    FUNCT_SUB: operation = ALU_SUB;
                    FUNCT_AND: operation = ALU_AND;
                    FUNCT_OR:  operation = ALU_OR;
                    FUNCT_SLT: operation = ALU_SLT;
                    FUNCT_NOR: operation = ALU_NOR;
                    default:   illegal   = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It captures the decoded operands and control,
// registers the ALU operation code and applies the EX forwarding muxes on the
// registered register values to feed the ALU.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    logic             valid_reg;
    logic [3:0]       operation_reg;
    logic             illegal_reg;
    logic [WIDTH-1:0] rs_reg;
    logic [WIDTH-1:0] rt_reg;
    logic [WIDTH-1:0] imm_reg;
    logic             alu_src_reg;
    logic [RADDR-1:0] wr_addr_reg;
    logic             reg_write_reg;
    logic             mem_read_reg;
    logic             mem_write_reg;
    logic             mem_to_reg_reg;

    logic [3:0]       dec_operation;
    logic             dec_illegal;
    logic [WIDTH-1:0] store_data_next;
    logic [WIDTH-1:0] data_a_next;

    alu_control u_alu_control (
        .alu_op    (bus.alu_op),
        .funct     (bus.funct),
        .operation (dec_operation),
        .illegal   (dec_illegal)
    );

    // Stage register: flush beats stall beats capture; flush keeps datapath fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg      <= 1'b0;
            operation_reg  <= ALU_ADD;
            illegal_reg    <= 1'b0;
            rs_reg         <= '0;
            rt_reg         <= '0;
            imm_reg        <= '0;
            alu_src_reg    <= 1'b0;
            wr_addr_reg    <= '0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
        end else if (bus.flush) begin
            valid_reg      <= 1'b0;
            illegal_reg    <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
        end else if (!bus.stall) begin
            operation_reg <= dec_operation;
            rs_reg        <= bus.rs_data;
            rt_reg        <= bus.rt_data;
            imm_reg       <= bus.imm;
            alu_src_reg   <= bus.alu_src;
            wr_addr_reg   <= bus.reg_dst ? bus.rd_addr : bus.rt_addr;
            if (bus.in_valid) begin
                valid_reg      <= 1'b1;
                illegal_reg    <= dec_illegal;
                // An unsupported instruction must not write state downstream
                reg_write_reg  <= bus.reg_write & ~dec_illegal;
                mem_read_reg   <= bus.mem_read  & ~dec_illegal;
                mem_write_reg  <= bus.mem_write & ~dec_illegal;
                mem_to_reg_reg <= bus.mem_to_reg;
            end else begin
                valid_reg      <= 1'b0;
                illegal_reg    <= 1'b0;
                reg_write_reg  <= 1'b0;
                mem_read_reg   <= 1'b0;
                mem_write_reg  <= 1'b0;
                mem_to_reg_reg <= 1'b0;
            end
        end
    end

    // Forwarding muxes stay combinational because the hazard unit decides in this cycle
    always_comb begin
        data_a_next     = rs_reg;
        store_data_next = rt_reg;
        case (bus.fwd_a)
            FWD_EXMEM, FWD_EXMEM2: data_a_next = bus.exmem_fwd;
            FWD_MEMWB:             data_a_next = bus.memwb_fwd;
            default:               data_a_next = rs_reg;
        endcase
        case (bus.fwd_b)
            FWD_EXMEM, FWD_EXMEM2: store_data_next = bus.exmem_fwd;
            FWD_MEMWB:             store_data_next = bus.memwb_fwd;
            default:               store_data_next = rt_reg;
        endcase
    end

    assign bus.ex_valid      = valid_reg;
    assign bus.operation     = operation_reg;
    assign bus.ex_illegal    = illegal_reg;
    assign bus.data_a        = data_a_next;
    assign bus.ex_store_data = store_data_next;
    assign bus.data_b        = alu_src_reg ? imm_reg : store_data_next;
    assign bus.ex_wr_addr    = wr_addr_reg;
    assign bus.ex_reg_write  = reg_write_reg;
    assign bus.ex_mem_read   = mem_read_reg;
    assign bus.ex_mem_write  = mem_write_reg;
    assign bus.ex_mem_to_reg = mem_to_reg_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage. It runs directed steps and then a randomized run.
// All of them are checked against a behavioural model of the stage.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if #(.WIDTH(32), .RADDR(5)) bus ();

    id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model of the EX-side contents
    logic        m_valid, m_ill, m_src, m_rw, m_mr, m_mw, m_m2r;
    logic [3:0]  m_op;
    logic [31:0] m_rs, m_rt, m_imm;
    logic [4:0]  m_wr;

    // Supported R-type instructions and their ALU codes
    logic [5:0] leg_funct [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    logic [3:0] leg_op    [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ref_decode(input logic [1:0] op, input logic [5:0] f,
                              output logic [3:0] code, output logic ill);
        code = 4'b0010;
        ill  = 1'b1;
        if (op == 2'd0) begin code = 4'b0010; ill = 1'b0; end
        else if (op == 2'd1) begin code = 4'b0110; ill = 1'b0; end
        else if (op == 2'd2) begin
            for (int i = 0; i < 6; i++)
                if (leg_funct[i] == f) begin code = leg_op[i]; ill = 1'b0; end
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] r);
        if (sel[1]) return bus.exmem_fwd;
        if (sel[0]) return bus.memwb_fwd;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ill = 0; m_src = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
        m_op = 4'b0010; m_rs = 0; m_rt = 0; m_imm = 0; m_wr = 0;
    endtask

    // Apply the stage rules to the inputs present just before a rising edge
    task automatic model_edge();
        logic [3:0] code;
        logic       ill;
        if (bus.flush) begin
            m_valid = 0; m_ill = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
        end else if (!bus.stall) begin
            ref_decode(bus.alu_op, bus.funct, code, ill);
            m_op = code; m_rs = bus.rs_data; m_rt = bus.rt_data; m_imm = bus.imm;
            m_src = bus.alu_src; m_wr = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
            if (bus.in_valid) begin
                m_valid = 1; m_ill = ill; m_m2r = bus.mem_to_reg;
                m_rw = ill ? 1'b0 : bus.reg_write;
                m_mr = ill ? 1'b0 : bus.mem_read;
                m_mw = ill ? 1'b0 : bus.mem_write;
            end else begin
                m_valid = 0; m_ill = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Compare the whole stage against the model; datapath only for real instructions
    task automatic check_state(input string tag);
        logic [31:0] st;
        chk({tag, ".valid"},     32'(bus.ex_valid),      32'(m_valid));
        chk({tag, ".op"},        32'(bus.operation),     32'(m_op));
        chk({tag, ".illegal"},   32'(bus.ex_illegal),    32'(m_ill));
        chk({tag, ".reg_write"}, 32'(bus.ex_reg_write),  32'(m_rw));
        chk({tag, ".mem_read"},  32'(bus.ex_mem_read),   32'(m_mr));
        chk({tag, ".mem_write"}, 32'(bus.ex_mem_write),  32'(m_mw));
        chk({tag, ".mem_to_reg"},32'(bus.ex_mem_to_reg), 32'(m_m2r));
        if (m_valid) begin
            st = ref_fwd(bus.fwd_b, m_rt);
            chk({tag, ".data_a"}, bus.data_a, ref_fwd(bus.fwd_a, m_rs));
            chk({tag, ".store"},  bus.ex_store_data, st);
            chk({tag, ".data_b"}, bus.data_b, m_src ? m_imm : st);
            chk({tag, ".wr_addr"}, 32'(bus.ex_wr_addr), 32'(m_wr));
        end
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] f,
                             input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid = 1; bus.alu_op = op; bus.funct = f;
        bus.rs_data = rs; bus.rt_data = rt;
    endtask

    initial begin
        rst_n = 0;
        bus.stall = 0; bus.flush = 0; bus.in_valid = 0; bus.alu_op = 0; bus.funct = 0;
        bus.rs_data = 0; bus.rt_data = 0; bus.imm = 0; bus.alu_src = 0; bus.reg_dst = 0;
        bus.rt_addr = 0; bus.rd_addr = 0; bus.reg_write = 0; bus.mem_read = 0;
        bus.mem_write = 0; bus.mem_to_reg = 0; bus.fwd_a = 0; bus.fwd_b = 0;
        bus.exmem_fwd = 32'hAA; bus.memwb_fwd = 32'hBB;
        model_reset();
        #12;
        chk("reset.op", 32'(bus.operation), 32'h2);
        chk("reset.valid", 32'(bus.ex_valid), 32'h0);
        rst_n = 1;

        // Asynchronous reset with the stage full
        set_instr(2'b10, 6'b100000, 32'h11, 32'h22);
        bus.reg_write = 1; bus.reg_dst = 1; bus.rd_addr = 5'd9;
        tick();
        check_state("full");
        #2 rst_n = 0;
        #1;
        model_reset();
        check_state("areset");
        chk("areset.data_a",  bus.data_a, 32'h0);
        chk("areset.data_b",  bus.data_b, 32'h0);
        chk("areset.wr_addr", 32'(bus.ex_wr_addr), 32'h0);
        rst_n = 1;
        tick();
        check_state("after_reset");

        // R-type capture for every supported funct
        for (int i = 0; i < 6; i++) begin
            set_instr(2'b10, leg_funct[i], 32'd5, 32'd7);
            bus.reg_dst = 1; bus.rd_addr = 5'd9; bus.rt_addr = 5'd3; bus.alu_src = 0;
            tick();
            chk($sformatf("rtype%0d.op", i), 32'(bus.operation), 32'(leg_op[i]));
            chk($sformatf("rtype%0d.data_a", i), bus.data_a, 32'd5);
            chk($sformatf("rtype%0d.data_b", i), bus.data_b, 32'd7);
            chk($sformatf("rtype%0d.wr", i), 32'(bus.ex_wr_addr), 32'd9);
            check_state($sformatf("rtype%0d", i));
        end

        // Immediate / store path
        set_instr(2'b00, 6'b0, 32'h100, 32'h1234);
        bus.alu_src = 1; bus.imm = 32'hFFFF_FFFC; bus.reg_write = 0; bus.mem_write = 1;
        bus.reg_dst = 0; bus.rt_addr = 5'd4;
        tick();
        chk("store.op", 32'(bus.operation), 32'h2);
        chk("store.data_b", bus.data_b, 32'hFFFF_FFFC);
        chk("store.sd", bus.ex_store_data, 32'h1234);
        chk("store.mw", 32'(bus.ex_mem_write), 32'h1);
        check_state("store");

        // Forwarding selects on both operands
        set_instr(2'b10, 6'b100000, 32'd1, 32'd2);
        bus.alu_src = 0; bus.mem_write = 0; bus.reg_write = 1;
        tick();
        for (int s = 0; s < 4; s++) begin
            bus.fwd_a = 2'(s); #1;
            chk($sformatf("fwd_a%0d", s), bus.data_a, (s == 0) ? 32'd1 : (s == 1) ? 32'hBB : 32'hAA);
        end
        bus.fwd_a = 0;
        for (int s = 0; s < 4; s++) begin
            bus.fwd_b = 2'(s); #1;
            chk($sformatf("fwd_b%0d.db", s), bus.data_b, (s == 0) ? 32'd2 : (s == 1) ? 32'hBB : 32'hAA);
            chk($sformatf("fwd_b%0d.sd", s), bus.ex_store_data, (s == 0) ? 32'd2 : (s == 1) ? 32'hBB : 32'hAA);
        end
        bus.fwd_b = 0;

        // Stall holds everything, then flush wins over stall
        set_instr(2'b10, 6'b101010, 32'h55, 32'h66);
        bus.reg_write = 1; bus.mem_to_reg = 1;
        tick();
        check_state("preload");
        bus.stall = 1;
        for (int c = 0; c < 3; c++) begin
            set_instr(2'b01, 6'(c), 32'(c + 100), 32'(c + 200));
            bus.reg_write = 0; bus.mem_read = 1;
            tick();
            chk($sformatf("stall%0d.op", c), 32'(bus.operation), 32'h7);
            chk($sformatf("stall%0d.a", c), bus.data_a, 32'h55);
            check_state($sformatf("stall%0d", c));
        end
        bus.flush = 1;
        tick();
        chk("flush.valid", 32'(bus.ex_valid), 32'h0);
        chk("flush.ctrl", {28'h0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}, 32'h0);
        check_state("flush");
        bus.flush = 0; bus.stall = 0; bus.mem_read = 0; bus.mem_to_reg = 0;

        // Unsupported funct, then a legal instruction clears it
        set_instr(2'b10, 6'b000000, 32'h1, 32'h2);
        bus.reg_write = 1;
        tick();
        chk("illegal.flag", 32'(bus.ex_illegal), 32'h1);
        chk("illegal.op", 32'(bus.operation), 32'h2);
        chk("illegal.rw", 32'(bus.ex_reg_write), 32'h0);
        set_instr(2'b10, 6'b100100, 32'h1, 32'h2);
        tick();
        chk("legal.flag", 32'(bus.ex_illegal), 32'h0);
        check_state("legal");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.alu_op = 2'($urandom);
            bus.funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : leg_funct[$urandom_range(0, 5)];
            bus.rs_data = $urandom; bus.rt_data = $urandom; bus.imm = $urandom;
            bus.alu_src = 1'($urandom); bus.reg_dst = 1'($urandom);
            bus.rt_addr = 5'($urandom); bus.rd_addr = 5'($urandom);
            bus.reg_write = 1'($urandom); bus.mem_read = 1'($urandom);
            bus.mem_write = 1'($urandom); bus.mem_to_reg = 1'($urandom);
            bus.fwd_a = 2'($urandom); bus.fwd_b = 2'($urandom);
            bus.exmem_fwd = $urandom; bus.memwb_fwd = $urandom;
            tick();
            check_state($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
